// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF response collector: FSM states,
// LFSR feedback tap positions and the majority-vote evaluation count.
package puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FIRE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Feedback taps besides the MSB: x^128 + x^29 + x^27 + x^2 + 1
    localparam int TAP_A = 28;
    localparam int TAP_B = 26;
    localparam int TAP_C = 1;

    localparam int VOTE_CNT = 3;

endpackage

// File: rtl/puf_lfsr.sv
// Challenge generator: Fibonacci LFSR that shifts left with the feedback bit in the LSB.
// Loading a zero seed substitutes 1 so the register can never lock up.
module puf_lfsr
    import puf_pkg::*;
#(
    parameter int             N    = 128,
    parameter logic [N-1:0]   SEED = {{(N-1){1'b0}}, 1'b1}
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         step,
    output logic [N-1:0] state
);

    logic [N-1:0] r_state;
    logic         w_fb;

    assign w_fb  = r_state[N-1] ^ r_state[TAP_A] ^ r_state[TAP_B] ^ r_state[TAP_C];
    assign state = r_state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= (load_val == '0) ? {{(N-1){1'b0}}, 1'b1} : load_val;
        end else if (step) begin
            r_state <= {r_state[N-2:0], w_fb};
        end
    end

endmodule

// File: rtl/puf_resp_collector.sv
// Arbiter-PUF controller: issues LFSR challenges, launches, samples the synchronised
// response and packs RESP_BITS of them per word. Define MAJORITY_VOTE_EN for 3-way voting.
module puf_resp_collector
    import puf_pkg::*;
#(
    parameter int           N         = 128,
    parameter int           RESP_BITS = 32,
    parameter int           SETTLE    = 4,
    parameter logic [127:0] SEED      = 128'h1
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 seed_load,
    input  logic [N-1:0]         seed,
    output logic                 puf_in,
    output logic [N-1:0]         puf_sel,
    input  logic                 puf_out,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy
);

    localparam int             BCW         = $clog2(RESP_BITS);
    localparam int             SCW         = $clog2(SETTLE);
    localparam logic [BCW-1:0] BIT_LAST    = BCW'(RESP_BITS - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
    localparam logic [N-1:0]   SEED_N      = N'(SEED);

    state_t                r_state;
    logic [BCW-1:0]        r_bit_cnt;
    logic [SCW-1:0]        r_settle_cnt;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [RESP_BITS-1:0]  r_shreg;
    logic [RESP_BITS-1:0]  r_resp_data;
    logic [N-1:0]          r_puf_sel;
    logic                  r_puf_in;
    logic                  r_resp_valid;
    logic                  r_busy;

    logic [N-1:0]          w_lfsr;
    logic                  w_lfsr_load;
    logic                  w_lfsr_step;
    logic                  w_last_eval;
    logic                  w_bit;

    assign puf_in     = r_puf_in;
    assign puf_sel    = r_puf_sel;
    assign resp_data  = r_resp_data;
    assign resp_valid = r_resp_valid;
    assign busy       = r_busy;

    assign w_lfsr_load = (r_state == ST_IDLE) && seed_load;
    assign w_lfsr_step = (r_state == ST_SAMPLE) && w_last_eval;

    puf_lfsr #(
        .N    (N),
        .SEED (SEED_N)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (w_lfsr_load),
        .load_val (seed),
        .step     (w_lfsr_step),
        .state    (w_lfsr)
    );

`ifdef MAJORITY_VOTE_EN
    logic [1:0] r_eval_cnt;
    logic [1:0] r_vote_cnt;
    logic [1:0] w_ones;

    // At most two earlier ones are stored, so the total never exceeds 3.
    assign w_ones      = r_vote_cnt + {1'b0, r_sync2};
    assign w_last_eval = (r_eval_cnt == 2'(VOTE_CNT - 1));
    assign w_bit       = w_ones[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_eval_cnt <= 2'd0;
            r_vote_cnt <= 2'd0;
        end else if (r_state == ST_SAMPLE) begin
            if (w_last_eval) begin
                r_eval_cnt <= 2'd0;
                r_vote_cnt <= 2'd0;
            end else begin
                r_eval_cnt <= r_eval_cnt + 2'd1;
                r_vote_cnt <= w_ones;
            end
        end
    end
`else
    assign w_last_eval = 1'b1;
    assign w_bit       = r_sync2;
`endif

    // Outputs are registered, so each is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_settle_cnt <= '0;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_shreg      <= '0;
            r_resp_data  <= '0;
            r_puf_sel    <= '0;
            r_puf_in     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_sync1 <= puf_out;
            r_sync2 <= r_sync1;
            case (r_state)
                ST_IDLE: begin
                    r_puf_in <= 1'b0;
                    if (start) begin
                        r_state   <= ST_SETUP;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    r_puf_sel    <= w_lfsr;
                    r_settle_cnt <= '0;
                    r_puf_in     <= 1'b1;
                    r_state      <= ST_FIRE;
                end
                ST_FIRE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_puf_in <= 1'b0;
                        r_state  <= ST_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SCW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (!w_last_eval) begin
                        r_state <= ST_SETUP;
                    end else begin
                        r_shreg <= {r_shreg[RESP_BITS-2:0], w_bit};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                            r_state   <= ST_SETUP;
                        end
                    end
                end
                ST_DONE: begin
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= r_shreg;
                    end else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_resp_collector.sv
// Directed bench for puf_resp_collector: reset, constant and modelled PUF responses,
// challenge order, backpressure, mid-run reset and (with MAJORITY_VOTE_EN) voting.
`timescale 1ns/1ps
module tb_puf_resp_collector;

    localparam int N  = 128;
    localparam int RB = 32;
    localparam int ST = 4;
`ifdef MAJORITY_VOTE_EN
    localparam int EVALS = 3;
`else
    localparam int EVALS = 1;
`endif
    localparam int BIT_CYC = EVALS * (ST + 2);
    localparam int LAT     = RB * BIT_CYC + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          seed_load = 1'b0;
    logic [N-1:0]  seed = '0;
    logic          resp_ready = 1'b0;
    logic          puf_out;
    logic          puf_in;
    logic [N-1:0]  puf_sel;
    logic [RB-1:0] resp_data;
    logic          resp_valid;
    logic          busy;

    int            mode = 0;
    logic [2:0]    pat = 3'b000;
    int            eval_idx;
    logic          pin_d;
    int            errors = 0;
    int            checks = 0;
    logic [RB-1:0] word4;
    logic [RB-1:0] held;
    int            cyc;

    puf_resp_collector #(
        .N(N), .RESP_BITS(RB), .SETTLE(ST), .SEED(128'h1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .seed_load(seed_load), .seed(seed),
        .puf_in(puf_in), .puf_sel(puf_sel), .puf_out(puf_out),
        .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            1:       puf_out = 1'b1;
            2:       puf_out = ^puf_sel;
            3:       puf_out = pat[eval_idx];
            default: puf_out = 1'b0;
        endcase
    end

    // Advance the evaluation index after each launch window closes.
    always @(posedge clk) begin
        pin_d <= puf_in;
        if (mode != 3)
            eval_idx <= 0;
        else if (!puf_in && pin_d)
            eval_idx <= (eval_idx == 2) ? 0 : eval_idx + 1;
    end

    task automatic check(input string tag, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic do_load, input logic [N-1:0] s);
        seed_load = do_load;
        seed      = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int elapsed);
        cyc = elapsed;
        while (resp_valid !== 1'b1 && cyc < LAT + 50) begin
            tick();
            cyc++;
        end
        check({tag, " latency"}, N'(cyc), N'(LAT));
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, " valid drop"}, N'(resp_valid), '0);
        check({tag, " idle busy"}, N'(busy), '0);
    endtask

    function automatic logic [N-1:0] lstep(input logic [N-1:0] l);
        return {l[N-2:0], l[N-1] ^ l[28] ^ l[26] ^ l[1]};
    endfunction

    function automatic logic [RB-1:0] golden(input logic [N-1:0] s);
        logic [N-1:0]  l;
        logic [RB-1:0] w;
        l = s;
        w = '0;
        for (int i = 0; i < RB; i++) begin
            w = {w[RB-2:0], ^l};
            l = lstep(l);
        end
        return w;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held with start asserted
        reset = 1'b0;
        start = 1'b1;
        tick();
        tick();
        check("rst puf_in", N'(puf_in), '0);
        check("rst puf_sel", puf_sel, '0);
        check("rst valid", N'(resp_valid), '0);
        check("rst busy", N'(busy), '0);
        check("rst data", N'(resp_data), '0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        check("post-rst busy", N'(busy), '0);
        check("post-rst puf_in", N'(puf_in), '0);

        // Constant PUF outputs
        mode = 1;
        kick(1'b0, '0);
        wait_valid("const1", 0);
        check("const1 data", N'(resp_data), N'(32'hFFFF_FFFF));
        handshake("const1");
        mode = 0;
        kick(1'b0, '0);
        wait_valid("const0", 0);
        check("const0 data", N'(resp_data), '0);
        handshake("const0");

        // Challenge order from a zero seed loaded with start
        mode = 2;
        kick(1'b1, '0);
        tick();
        check("order sel0", puf_sel, N'(1));
        check("order fire puf_in", N'(puf_in), N'(1));
        for (int i = 0; i < ST; i++) tick();
        check("order sample puf_in", N'(puf_in), '0);
        check("order sel0 stable", puf_sel, N'(1));
        for (int i = 0; i < BIT_CYC - ST; i++) tick();
        check("order sel1", puf_sel, N'(2));
        for (int i = 0; i < BIT_CYC; i++) tick();
        check("order sel2", puf_sel, lstep(N'(2)));
        wait_valid("order", 1 + 2 * BIT_CYC);
        check("order data", N'(resp_data), N'(golden(N'(1))));
        handshake("order");
        kick(1'b1, N'(5));
        tick();
        check("seed5 sel0", puf_sel, N'(5));
        wait_valid("seed5", 1);
        check("seed5 data", N'(resp_data), N'(golden(N'(5))));
        handshake("seed5");

        // Modelled PUF with backpressure
        word4 = golden(N'(1));
        kick(1'b1, N'(1));
        wait_valid("xor", 0);
        check("xor data", N'(resp_data), N'(word4));
        held = resp_data;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) start = 1'b1;
            tick();
            start = 1'b0;
            check("hold data", N'(resp_data), N'(held));
            check("hold valid", N'(resp_valid), N'(1));
        end
        check("hold busy", N'(busy), N'(1));
        handshake("xor");
        tick();
        check("start ignored", N'(busy), '0);

        // Reset in the 10th launch window, then replay from SEED
        kick(1'b0, '0);
        for (int i = 0; i < 1 + 9 * (ST + 2); i++) tick();
        check("10th fire puf_in", N'(puf_in), N'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort puf_in", N'(puf_in), '0);
        check("abort puf_sel", puf_sel, '0);
        check("abort data", N'(resp_data), '0);
        check("abort valid", N'(resp_valid), '0);
        check("abort busy", N'(busy), '0);
        tick();
        kick(1'b0, '0);
        wait_valid("replay", 0);
        check("replay data", N'(resp_data), N'(word4));
        handshake("replay");

`ifdef MAJORITY_VOTE_EN
        // Majority of each evaluation triple
        mode = 3;
        pat  = 3'b101;
        kick(1'b0, '0);
        wait_valid("vote101", 0);
        check("vote101 data", N'(resp_data), N'(32'hFFFF_FFFF));
        handshake("vote101");
        pat = 3'b010;
        kick(1'b0, '0);
        wait_valid("vote010", 0);
        check("vote010 data", N'(resp_data), '0);
        handshake("vote010");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
